// File: rtl/mac_array_ctrl_if.sv
// Handshake bundle between the TPU sequencer / weight memory and the MAC-row controller.
interface mac_array_ctrl_if #(
    parameter int DATA_SIZE  = 8,
    parameter int NUM_MACS   = 4,
    parameter int ADDR_WIDTH = 8,
    parameter int CNT_WIDTH  = 16
);
    logic                  start;
    logic [ADDR_WIDTH-1:0] base_addr;
    logic [CNT_WIDTH-1:0]  num_cols;
    logic                  wmem_rd;
    logic [ADDR_WIDTH-1:0] wmem_addr;
    logic [DATA_SIZE-1:0]  wmem_rdata;
    logic [NUM_MACS-1:0]   win_request;
    logic [DATA_SIZE-1:0]  win;
    logic [NUM_MACS-1:0]   win_valid;
    logic [NUM_MACS-1:0]   instr;
    logic                  busy;
    logic                  done;

    modport master (
        output start, base_addr, num_cols, wmem_rdata, win_request,
        input  wmem_rd, wmem_addr, win, win_valid, instr, busy, done
    );

    modport slave (
        input  start, base_addr, num_cols, wmem_rdata, win_request,
        output wmem_rd, wmem_addr, win, win_valid, instr, busy, done
    );
endinterface

// File: rtl/mac_array_ctrl.sv
// Sequences one row of MACs through weight load (round-robin over requests),
// compute for a programmed column count, and a drain covering the systolic skew.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | waiting for start; all outputs quiet
// LOAD    | granting one requesting, not-yet-loaded MAC per cycle
// COMPUTE | one settle cycle (last weight lands), then instr for num_cols
// DRAIN   | instr low for NUM_MACS-1 cycles to flush the skew
// DONE    | one-cycle done pulse, busy still high
module mac_array_ctrl #(
    parameter int DATA_SIZE  = 8,
    parameter int NUM_MACS   = 4,
    parameter int ADDR_WIDTH = 8,
    parameter int CNT_WIDTH  = 16
) (
    input logic             clock,
    input logic             reset,
    mac_array_ctrl_if.slave bus
);
    localparam int PW = $clog2(NUM_MACS);

    typedef logic [PW-1:0]         ptr_t;
    typedef logic [NUM_MACS-1:0]   mask_t;
    typedef logic [ADDR_WIDTH-1:0] addr_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_COMPUTE,
        S_DRAIN,
        S_DONE
    } state_t;

    localparam mask_t ALL_ONES = '1;

    state_t               state_q;
    mask_t                loaded_q;
    mask_t                gnt_oh_q;
    mask_t                win_valid_q;
    mask_t                instr_q;
    ptr_t                 rr_q;
    ptr_t                 drain_q;
    addr_t                base_q;
    addr_t                addr_q;
    logic [CNT_WIDTH-1:0] cols_q;
    logic [CNT_WIDTH-1:0] col_cnt_q;
    logic                 rd_q;
    logic                 busy_q;
    logic                 done_q;
    logic [DATA_SIZE-1:0] win_last_q;

    logic  load_en;
    mask_t elig;
    logic  gnt_any_d;
    ptr_t  gnt_idx_d;
    ptr_t  scan_idx;
    mask_t gnt_oh_d;
    ptr_t  rr_d;
    addr_t gnt_addr_d;

    // The accepting start cycle already arbitrates, so the first read strobe
    // appears on the first LOAD cycle.
    always_comb begin
        load_en = ((state_q == S_LOAD) && (loaded_q != ALL_ONES)) ||
                  ((state_q == S_IDLE) && bus.start);
        elig = '0;
        if (load_en) begin
            elig = bus.win_request & ((state_q == S_IDLE) ? ALL_ONES : ~loaded_q);
        end

        gnt_any_d = 1'b0;
        gnt_idx_d = '0;
        scan_idx  = '0;
        for (int i = 0; i < NUM_MACS; i++) begin
            scan_idx = ptr_t'((int'(rr_q) + i) % NUM_MACS);
            if (!gnt_any_d && elig[scan_idx]) begin
                gnt_any_d = 1'b1;
                gnt_idx_d = scan_idx;
            end
        end

        gnt_oh_d   = gnt_any_d ? (mask_t'(1) << gnt_idx_d) : '0;
        rr_d       = (gnt_idx_d == ptr_t'(NUM_MACS - 1)) ? '0 : gnt_idx_d + 1'b1;
        gnt_addr_d = ((state_q == S_IDLE) ? bus.base_addr : base_q) + addr_t'(gnt_idx_d);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            loaded_q    <= '0;
            gnt_oh_q    <= '0;
            win_valid_q <= '0;
            instr_q     <= '0;
            rr_q        <= '0;
            drain_q     <= '0;
            base_q      <= '0;
            addr_q      <= '0;
            cols_q      <= '0;
            col_cnt_q   <= '0;
            rd_q        <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            win_last_q  <= '0;
        end else begin
            rd_q <= gnt_any_d;
            if (gnt_any_d) begin
                addr_q   <= gnt_addr_d;
                gnt_oh_q <= gnt_oh_d;
                rr_q     <= rr_d;
            end
            win_valid_q <= rd_q ? gnt_oh_q : '0;
            if (|win_valid_q) begin
                win_last_q <= bus.wmem_rdata;
            end
            done_q <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        base_q   <= bus.base_addr;
                        cols_q   <= bus.num_cols;
                        loaded_q <= gnt_oh_d;
                        busy_q   <= 1'b1;
                        state_q  <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (loaded_q == ALL_ONES) begin
                        col_cnt_q <= '0;
                        if (cols_q == '0) begin
                            drain_q <= ptr_t'(NUM_MACS - 2);
                            state_q <= S_DRAIN;
                        end else begin
                            state_q <= S_COMPUTE;
                        end
                    end else begin
                        loaded_q <= loaded_q | gnt_oh_d;
                    end
                end
                S_COMPUTE: begin
                    // instr still low means this is the cycle the last weight lands
                    if (instr_q == '0) begin
                        instr_q <= ALL_ONES;
                    end else if (col_cnt_q == cols_q - 1'b1) begin
                        instr_q <= '0;
                        drain_q <= ptr_t'(NUM_MACS - 2);
                        state_q <= S_DRAIN;
                    end else begin
                        col_cnt_q <= col_cnt_q + 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (drain_q == '0) begin
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        drain_q <= drain_q - 1'b1;
                    end
                end
                S_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.wmem_rd   = rd_q;
    assign bus.wmem_addr = addr_q;
    assign bus.win_valid = win_valid_q;
    assign bus.win       = (|win_valid_q) ? bus.wmem_rdata : win_last_q;
    assign bus.instr     = instr_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
endmodule

// File: tb/tb_mac_array_ctrl.sv
// Directed bench for mac_array_ctrl: cycle table for a basic pass plus pass-level
// sequences for round-robin, stalls, address wrap, zero columns and reset abort.
module tb_mac_array_ctrl;
    localparam int NM = 4;

    logic clock;
    logic reset;
    int   n_vec;
    int   n_bad;

    mac_array_ctrl_if bus ();

    mac_array_ctrl dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // weight memory model: mem[a] = a, data one cycle after the strobe
    always @(posedge clock) begin
        if (bus.wmem_rd) bus.wmem_rdata <= bus.wmem_addr;
    end

    typedef struct {
        logic       start;
        logic [3:0] req;
        logic       rd;
        logic [7:0] addr;
        logic [3:0] wv;
        logic [7:0] win;
        logic [3:0] instr;
        logic       busy;
        logic       done;
    } vec_t;

    vec_t tbl [16];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        n_vec++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, want);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [7:0] ord4(input int a, input int b, input int c, input int d);
        return {2'(d), 2'(c), 2'(b), 2'(a)};
    endfunction

    // Runs one pass from IDLE. ord lists the expected grant order (2 bits per grant,
    // first grant in the low bits); requests switch from req0 to req1 at cycle sw;
    // when ign > 0, foreign start pulses are injected at cycles ign and ign+5.
    task automatic run_pass(input string tag, input logic [7:0] base, input logic [15:0] cols,
                            input logic [3:0] req0, input logic [3:0] req1, input int sw,
                            input int ign, input logic [7:0] ord, input int exp_last_rd);
        int         rd_n, wv_n, instr_n, first_instr, last_rd, last_wv, done_c, exp_done;
        bit         fin;
        logic [1:0] idx;
        logic [7:0] ea;
        logic [3:0] ew;
        rd_n = 0; wv_n = 0; instr_n = 0;
        first_instr = -1; last_rd = -1; last_wv = -1; done_c = -1;
        fin = 1'b0;
        for (int c = 0; c < 200 && !fin; c++) begin
            bus.start       = (c == 0) || ((ign > 0) && ((c == ign) || (c == ign + 5)));
            bus.base_addr   = (c == 0) ? base : 8'hA5;
            bus.num_cols    = (c == 0) ? cols : 16'd9;
            bus.win_request = (c < sw) ? req0 : req1;
            if (bus.wmem_rd) begin
                if (rd_n < NM) begin
                    idx = 2'(ord >> (2 * rd_n));
                    ea  = base + 8'(idx);
                    chk({tag, "/addr"}, 32'(bus.wmem_addr), 32'(ea));
                end
                rd_n++;
                last_rd = c;
            end
            if (bus.win_valid != 4'h0) begin
                if (wv_n < NM) begin
                    idx = 2'(ord >> (2 * wv_n));
                    ea  = base + 8'(idx);
                    ew  = 4'b0001 << idx;
                    chk({tag, "/win_valid"}, 32'(bus.win_valid), 32'(ew));
                    chk({tag, "/win"}, 32'(bus.win), 32'(ea));
                end
                wv_n++;
                last_wv = c;
            end
            if (bus.instr != 4'h0) begin
                chk({tag, "/instr_val"}, 32'(bus.instr), 32'hF);
                if (first_instr < 0) first_instr = c;
                instr_n++;
            end
            if (bus.done) begin
                done_c = c;
                fin    = 1'b1;
            end
            step();
        end
        bus.start = 1'b0;
        exp_done = exp_last_rd + NM + ((cols != 16'd0) ? int'(cols) + 1 : 0);
        chk({tag, "/rd_count"}, 32'(rd_n), 32'(NM));
        chk({tag, "/wv_count"}, 32'(wv_n), 32'(NM));
        chk({tag, "/last_rd_cycle"}, 32'(last_rd), 32'(exp_last_rd));
        chk({tag, "/last_wv_cycle"}, 32'(last_wv), 32'(exp_last_rd + 1));
        chk({tag, "/instr_cycles"}, 32'(instr_n), 32'(cols));
        if (cols != 16'd0) chk({tag, "/first_instr"}, 32'(first_instr), 32'(exp_last_rd + 2));
        chk({tag, "/done_cycle"}, 32'(done_c), 32'(exp_done));
        chk({tag, "/busy_after"}, 32'(bus.busy), 32'h0);
        chk({tag, "/done_after"}, 32'(bus.done), 32'h0);
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "/wmem_rd"}, 32'(bus.wmem_rd), 32'h0);
        chk({tag, "/wmem_addr"}, 32'(bus.wmem_addr), 32'h0);
        chk({tag, "/win"}, 32'(bus.win), 32'h0);
        chk({tag, "/win_valid"}, 32'(bus.win_valid), 32'h0);
        chk({tag, "/instr"}, 32'(bus.instr), 32'h0);
        chk({tag, "/busy"}, 32'(bus.busy), 32'h0);
        chk({tag, "/done"}, 32'(bus.done), 32'h0);
    endtask

    initial begin
        int seen;
        n_vec = 0;
        n_bad = 0;

        // basic pass, base 0x10, five columns, all MACs requesting
        tbl[0]  = '{1'b1, 4'hF, 1'b0, 8'h00, 4'h0, 8'h00, 4'h0, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 4'hF, 1'b1, 8'h10, 4'h0, 8'h00, 4'h0, 1'b1, 1'b0};
        tbl[2]  = '{1'b0, 4'hF, 1'b1, 8'h11, 4'h1, 8'h10, 4'h0, 1'b1, 1'b0};
        tbl[3]  = '{1'b0, 4'hF, 1'b1, 8'h12, 4'h2, 8'h11, 4'h0, 1'b1, 1'b0};
        tbl[4]  = '{1'b0, 4'hF, 1'b1, 8'h13, 4'h4, 8'h12, 4'h0, 1'b1, 1'b0};
        tbl[5]  = '{1'b0, 4'hF, 1'b0, 8'h13, 4'h8, 8'h13, 4'h0, 1'b1, 1'b0};
        for (int i = 6; i <= 10; i++) tbl[i] = '{1'b0, 4'hF, 1'b0, 8'h13, 4'h0, 8'h13, 4'hF, 1'b1, 1'b0};
        for (int i = 11; i <= 13; i++) tbl[i] = '{1'b0, 4'hF, 1'b0, 8'h13, 4'h0, 8'h13, 4'h0, 1'b1, 1'b0};
        tbl[14] = '{1'b0, 4'hF, 1'b0, 8'h13, 4'h0, 8'h13, 4'h0, 1'b1, 1'b1};
        tbl[15] = '{1'b0, 4'hF, 1'b0, 8'h13, 4'h0, 8'h13, 4'h0, 1'b0, 1'b0};

        bus.start       = 1'b0;
        bus.base_addr   = 8'h00;
        bus.num_cols    = 16'd0;
        bus.win_request = 4'h0;
        reset = 1'b1;
        #3 reset = 1'b0;
        @(posedge clock);
        #1;
        chk_quiet("reset");
        repeat (2) @(posedge clock);
        #1 reset = 1'b1;
        step();

        for (int i = 0; i < 16; i++) begin
            bus.start       = tbl[i].start;
            bus.win_request = tbl[i].req;
            bus.base_addr   = 8'h10;
            bus.num_cols    = 16'd5;
            chk($sformatf("basic[%0d]/wmem_rd", i), 32'(bus.wmem_rd), 32'(tbl[i].rd));
            chk($sformatf("basic[%0d]/wmem_addr", i), 32'(bus.wmem_addr), 32'(tbl[i].addr));
            chk($sformatf("basic[%0d]/win_valid", i), 32'(bus.win_valid), 32'(tbl[i].wv));
            chk($sformatf("basic[%0d]/win", i), 32'(bus.win), 32'(tbl[i].win));
            chk($sformatf("basic[%0d]/instr", i), 32'(bus.instr), 32'(tbl[i].instr));
            chk($sformatf("basic[%0d]/busy", i), 32'(bus.busy), 32'(tbl[i].busy));
            chk($sformatf("basic[%0d]/done", i), 32'(bus.done), 32'(tbl[i].done));
            step();
        end
        bus.start = 1'b0;

        // rr_ptr is 0 here; it stays 0 after each full in-order pass
        run_pass("wrap", 8'hFE, 16'd2, 4'hF, 4'hF, 0, -1, ord4(0, 1, 2, 3), 4);
        run_pass("cols0", 8'h05, 16'd0, 4'hF, 4'hF, 0, -1, ord4(0, 1, 2, 3), 4);
        run_pass("rr1", 8'h20, 16'd1, 4'b0100, 4'hF, 1, -1, ord4(2, 3, 0, 1), 4);
        // rr_ptr now 2: MAC2 not requesting, so MAC3 first; MAC2 joins at cycle 4
        run_pass("rr2", 8'h20, 16'd1, 4'b1011, 4'hF, 4, -1, ord4(3, 0, 1, 2), 5);
        // rr_ptr now 3: MAC1 alone, everyone else 20 cycles late
        run_pass("stall", 8'h60, 16'd1, 4'b0010, 4'hF, 20, -1, ord4(1, 2, 3, 0), 23);
        // rr_ptr now 1; foreign start pulses during LOAD and COMPUTE
        run_pass("busy_start", 8'h30, 16'd3, 4'hF, 4'hF, 0, 2, ord4(1, 2, 3, 0), 4);

        // reset in the third compute cycle aborts the pass
        bus.start       = 1'b1;
        bus.base_addr   = 8'h40;
        bus.num_cols    = 16'd5;
        bus.win_request = 4'hF;
        step();
        bus.start = 1'b0;
        repeat (7) step();
        chk("abort/instr_mid", 32'(bus.instr), 32'hF);
        #2 reset = 1'b0;
        #1;
        chk_quiet("abort");
        step();
        reset = 1'b1;
        seen = 0;
        repeat (20) begin
            step();
            if (bus.done) seen++;
        end
        chk("abort/no_done", 32'(seen), 32'h0);
        chk("abort/busy_idle", 32'(bus.busy), 32'h0);

        // reset cleared rr_ptr, so grants restart at MAC0
        run_pass("post_reset", 8'h50, 16'd2, 4'hF, 4'hF, 0, -1, ord4(0, 1, 2, 3), 4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
